// File: rtl/cacheline_adaptor_if.sv
// Bus bundle between the cache's physical-memory port and the burst memory.
// Carries both sides of cacheline_adaptor:
//   cache side : address_i, line_i, read_i, write_i  ->  line_o, resp_o
//   memory side: burst_i, resp_i                      ->  address_o, burst_o, read_o, write_o
// Modport slave is the adaptor's view; modport master is the view of
// whatever drives the cache requests and models memory.
interface cacheline_adaptor_if #(
  parameter int LINE_BITS  = 256,
  parameter int BURST_BITS = 64,
  parameter int ADDR_BITS  = 32
);
  logic [ADDR_BITS-1:0]  address_i;
  logic [LINE_BITS-1:0]  line_i;
  logic                  read_i;
  logic                  write_i;
  logic [LINE_BITS-1:0]  line_o;
  logic                  resp_o;
  logic [ADDR_BITS-1:0]  address_o;
  logic [BURST_BITS-1:0] burst_o;
  logic                  read_o;
  logic                  write_o;
  logic [BURST_BITS-1:0] burst_i;
  logic                  resp_i;

  modport slave (
    input  address_i, line_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, address_o, burst_o, read_o, write_o
  );

  modport master (
    output address_i, line_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, burst_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns one full-line cache read (fill) or write
// (writeback) into a burst of LINE_BITS/BURST_BITS beats on the memory side.
// One line is buffered and one transaction is in flight at a time.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - cacheline_adaptor_if.slave; cache request/response and memory
//          burst signals (see the interface file for the signal list)
module cacheline_adaptor #(
  parameter int LINE_BITS  = 256,
  parameter int BURST_BITS = 64,
  parameter int ADDR_BITS  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  cacheline_adaptor_if.slave   bus
);

  localparam int NBEATS = LINE_BITS / BURST_BITS;
  localparam int CNT_W  = $clog2(NBEATS);
  localparam int OFFS   = $clog2(LINE_BITS / 8);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [LINE_BITS-1:0]  line_buf;
  logic [LINE_BITS-1:0]  line_asm;
  logic [LINE_BITS-1:0]  line_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic                  last_beat;

  // Next state; write wins over read when both are requested in IDLE.
  always_comb begin
    state_nxt = state;
    last_beat = (cnt == CNT_W'(NBEATS - 1));
    case (state)
      IDLE: begin
        if (bus.write_i)     state_nxt = WR;
        else if (bus.read_i) state_nxt = RD;
      end
      RD, WR: begin
        if (bus.resp_i && last_beat) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Line buffer with the incoming beat merged in, so the final beat can be
  // published to line_o in the same cycle it arrives.
  always_comb begin
    line_asm = line_buf;
    line_asm[cnt*BURST_BITS +: BURST_BITS] = bus.burst_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      line_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.write_i || bus.read_i) begin
            addr_q <= {bus.address_i[ADDR_BITS-1:OFFS], {OFFS{1'b0}}};
            cnt    <= '0;
          end
        end
        RD: begin
          if (bus.resp_i) begin
            cnt <= last_beat ? '0 : cnt + 1'b1;
            if (last_beat) line_q <= line_asm;
          end
        end
        WR: begin
          if (bus.resp_i) cnt <= last_beat ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Line buffer holds the writeback line or the partially filled read line;
  // a reset only needs to return the control state, stale data is harmless.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.write_i)     line_buf <= bus.line_i;
    else if (state == RD && bus.resp_i)   line_buf <= line_asm;
  end

  assign bus.read_o    = (state == RD);
  assign bus.write_o   = (state == WR);
  assign bus.resp_o    = (state == DONE);
  assign bus.burst_o   = (state == WR) ? line_buf[cnt*BURST_BITS +: BURST_BITS] : '0;
  assign bus.line_o    = line_q;
  assign bus.address_o = addr_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;
  localparam int LB = 256;
  localparam int BB = 64;
  localparam int AB = 32;
  localparam int NB = LB / BB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cacheline_adaptor_if #(.LINE_BITS(LB), .BURST_BITS(BB), .ADDR_BITS(AB)) bus();

  cacheline_adaptor #(.LINE_BITS(LB), .BURST_BITS(BB), .ADDR_BITS(AB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          wr;
    logic [AB-1:0] addr;
    logic [LB-1:0] line;
  } exp_t;

  exp_t          sb[$];
  logic [LB-1:0] mem [logic [AB-1:0]];
  logic [LB-1:0] wr_cap;
  logic [LB-1:0] last_fill;
  logic [LB-1:0] rsp_tmp;
  bit            pat[$];
  bit            go;
  bit            prev_resp;
  exp_t          mon_e;
  int            rb;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] r;
    for (int i = 0; i < LB / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [AB-1:0] align(input logic [AB-1:0] a);
    return {a[AB-1:5], 5'b0};
  endfunction

  // Memory model: drives beats (with stalls) while the adaptor requests,
  // and throws stray resp_i pulses at it while it does not.
  initial begin
    bus.resp_i  = 1'b0;
    bus.burst_i = '0;
    rb          = 0;
    wr_cap      = '0;
    forever begin
      @(negedge clk);
      if (bus.read_o || bus.write_o) begin
        if (pat.size() > 0) go = pat.pop_front();
        else                go = ($urandom_range(0, 3) != 0);
        bus.resp_i  = go;
        bus.burst_i = {$urandom, $urandom};
        if (go && rb < NB) begin
          if (bus.read_o) begin
            rsp_tmp     = mem[bus.address_o];
            bus.burst_i = rsp_tmp[rb*BB +: BB];
          end else if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL write beat: got beat with no transaction pending, required none");
          end else begin
            rsp_tmp = sb[0].line;
            chk("write beat data", LB'(bus.burst_o), LB'(rsp_tmp[rb*BB +: BB]));
            chk("read_o during write", LB'(bus.read_o), LB'(1'b0));
            wr_cap[rb*BB +: BB] = bus.burst_o;
          end
          rb++;
        end
      end else begin
        rb          = 0;
        bus.resp_i  = 1'($urandom_range(0, 1));
        bus.burst_i = {$urandom, $urandom};
      end
    end
  end

  // Scoreboard monitor: every completion pulse is matched against the
  // oldest outstanding transaction.
  initial begin
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.resp_o) begin
        chk("resp_o single pulse", LB'(prev_resp), LB'(1'b0));
        chk("requests low in done", LB'({bus.read_o, bus.write_o}), LB'(2'b00));
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL resp_o: got unexpected pulse, required none");
        end else begin
          mon_e = sb.pop_front();
          chk("address_o", LB'(bus.address_o), LB'(align(mon_e.addr)));
          if (mon_e.wr) begin
            chk("written line", wr_cap, mon_e.line);
            chk("line_o after write", bus.line_o, last_fill);
          end else begin
            chk("line_o fill", bus.line_o, mon_e.line);
            last_fill = mon_e.line;
          end
        end
      end
      prev_resp = bus.resp_o;
    end
  end

  // Issues one request at the current negedge and holds it until resp_o.
  // With hold set the request stays up through the completion cycle.
  task automatic txn(input bit rd, input bit wr, input logic [AB-1:0] a,
                     input logic [LB-1:0] l, input bit hold, output int lat);
    exp_t e;
    e.wr   = wr;
    e.addr = a;
    e.line = l;
    if (!wr) mem[align(a)] = l;
    bus.address_i = a;
    bus.line_i    = wr ? l : rand_line();
    bus.read_i    = rd;
    bus.write_i   = wr;
    sb.push_back(e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_o && lat < 300);
    if (!bus.resp_o) begin
      n_cmp++; n_bad++;
      $display("FAIL completion timeout: got no resp_o in %0d cycles, required a pulse", lat);
    end
    if (hold) begin
      @(posedge clk);
      #1;
    end
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    if (hold) begin
      @(negedge clk);
      chk("no re-accept after done", LB'({bus.read_o, bus.write_o}), LB'(2'b00));
    end
  endtask

  initial begin
    int            lat;
    int            kind;
    logic [AB-1:0] a;
    logic [LB-1:0] l;

    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = '0;
    bus.line_i    = '0;
    last_fill     = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset resp/read/write", LB'({bus.resp_o, bus.read_o, bus.write_o}), LB'(3'b000));
    chk("reset address_o", LB'(bus.address_o), '0);
    chk("reset burst_o", LB'(bus.burst_o), '0);
    chk("reset line_o", bus.line_o, '0);
    rst = 1'b0;

    // Stray resp_i while idle must not disturb anything.
    repeat (6) begin
      @(negedge clk);
      chk("idle requests", LB'({bus.read_o, bus.write_o, bus.resp_o}), LB'(3'b000));
      chk("idle line_o", bus.line_o, '0);
    end

    // Unstalled fill: 1 accept + 4 beats + done.
    pat = '{1, 1, 1, 1};
    txn(1'b1, 1'b0, 32'h0000_1234,
        {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0, lat);
    chk("read latency", LB'(lat + 1), LB'(6));

    // Writeback of a known line.
    @(negedge clk);
    txn(1'b0, 1'b1, 32'h8000_00FF,
        {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 1'b0, lat);

    // Fill with stalls 1,0,0,1,1,0,1: seven beat cycles.
    @(negedge clk);
    pat = '{1, 0, 0, 1, 1, 0, 1};
    txn(1'b1, 1'b0, $urandom, rand_line(), 1'b0, lat);
    chk("stalled read latency", LB'(lat + 1), LB'(9));

    // Reset after two beats of a fill.
    @(negedge clk);
    a = $urandom;
    l = rand_line();
    mem[align(a)] = l;
    pat = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    bus.address_i = a;
    bus.read_i    = 1'b1;
    repeat (4) @(negedge clk);
    rst         = 1'b1;
    bus.read_i  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pat.delete();
    last_fill = '0;
    chk("read_o after abort", LB'(bus.read_o), LB'(1'b0));
    chk("line_o after abort", bus.line_o, '0);
    chk("address_o after abort", LB'(bus.address_o), '0);
    repeat (3) @(negedge clk);
    txn(1'b1, 1'b0, $urandom, rand_line(), 1'b0, lat);

    // Both requests: write wins; then back-to-back write and read.
    @(negedge clk);
    txn(1'b1, 1'b1, $urandom, rand_line(), 1'b0, lat);
    txn(1'b0, 1'b1, $urandom, rand_line(), 1'b0, lat);
    txn(1'b1, 1'b0, $urandom, rand_line(), 1'b1, lat);

    // Random mix with random stalls, idle gaps and held requests.
    repeat (40) begin
      kind = $urandom_range(0, 2);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("gap line_o", bus.line_o, last_fill);
        chk("gap requests", LB'({bus.read_o, bus.write_o}), LB'(2'b00));
      end
      @(negedge clk);
      txn(kind != 1, kind != 0, $urandom, rand_line(), 1'($urandom_range(0, 1)), lat);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard drained", LB'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
